// File: rtl/input_tokenizer.sv
// Keypad command consumer: builds decimal numbers from digit codes and emits
// NUM/OP/paren/OK/CLR tokens through a small FIFO with a valid/ready handshake.
module input_tokenizer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int IC_N  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IC_N-1:0] cmd_i,
    output logic            tok_valid_o,
    input  logic            tok_ready_i,
    output logic [2:0]      tok_kind_o,
    output logic [W-1:0]    tok_value_o,
    output logic [W-1:0]    entry_val_o,
    output logic            entry_active_o,
    output logic            drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IC_N-1:0] IC_NONE = IC_N'(0);
    localparam logic [IC_N-1:0] IC_NUM0 = IC_N'(1);
    localparam logic [IC_N-1:0] IC_NUM9 = IC_N'(10);
    localparam logic [IC_N-1:0] IC_OPAD = IC_N'(11);
    localparam logic [IC_N-1:0] IC_OPLS = IC_N'(17);
    localparam logic [IC_N-1:0] IC_EXLP = IC_N'(18);
    localparam logic [IC_N-1:0] IC_EXRP = IC_N'(19);
    localparam logic [IC_N-1:0] IC_CTOK = IC_N'(20);
    localparam logic [IC_N-1:0] IC_CLBK = IC_N'(21);
    localparam logic [IC_N-1:0] IC_CLCL = IC_N'(22);

    typedef enum logic [2:0] {
        TK_NUM  = 3'd0,
        TK_OP   = 3'd1,
        TK_LPAR = 3'd2,
        TK_RPAR = 3'd3,
        TK_OK   = 3'd4,
        TK_CLR  = 3'd5
    } tok_kind_e;

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  ndig_q, ndig_d;
    logic          drop_q, drop_d;
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count, wnext;
    tok_kind_e     kind_mem [DEPTH];
    logic [W-1:0]  val_mem  [DEPTH];

    logic          pop, entry_active;
    logic [AW+1:0] free_slots, need;
    logic          we0, we1;
    tok_kind_e     wk0, wk1;
    logic [W-1:0]  wv0, wv1;
    logic [W+3:0]  nxt;
    logic          is_digit, is_tok;
    tok_kind_e     ck;
    logic [W-1:0]  cv;

    assign count        = wptr_q - rptr_q;
    assign wnext        = wptr_q + (AW+1)'(1);
    assign tok_valid_o  = (count != '0);
    assign pop          = tok_valid_o && tok_ready_i;
    assign entry_active = (ndig_q != '0);
    // A pop in this cycle frees a slot that a push may reuse immediately.
    assign free_slots   = (AW+2)'(DEPTH) - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    assign need         = entry_active ? (AW+2)'(2) : (AW+2)'(1);
    assign is_digit     = (cmd_i >= IC_NUM0) && (cmd_i <= IC_NUM9);
    assign nxt          = {4'b0000, acc_q} * (W+4)'(10) + (W+4)'(cmd_i - IC_NUM0);

    assign tok_kind_o     = tok_valid_o ? kind_mem[rptr_q[AW-1:0]] : TK_NUM;
    assign tok_value_o    = tok_valid_o ? val_mem[rptr_q[AW-1:0]] : '0;
    assign entry_val_o    = acc_q;
    assign entry_active_o = entry_active;
    assign drop_o         = drop_q;

    always_comb begin
        is_tok = 1'b0;
        ck     = TK_OP;
        cv     = '0;
        if ((cmd_i >= IC_OPAD) && (cmd_i <= IC_OPLS)) begin
            is_tok = 1'b1;
            cv     = W'(cmd_i - IC_OPAD);
        end else if (cmd_i == IC_EXLP) begin
            is_tok = 1'b1;
            ck     = TK_LPAR;
        end else if (cmd_i == IC_EXRP) begin
            is_tok = 1'b1;
            ck     = TK_RPAR;
        end else if (cmd_i == IC_CTOK) begin
            is_tok = 1'b1;
            ck     = TK_OK;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        ndig_d = ndig_q;
        drop_d = 1'b0;
        we0    = 1'b0;
        we1    = 1'b0;
        wk0    = TK_NUM;
        wv0    = '0;
        wk1    = TK_NUM;
        wv1    = '0;
        wptr_d = wptr_q;
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
        if (cmd_i == IC_CLCL) begin
            // Clear flushes everything queued, including a head popped this cycle.
            acc_d  = '0;
            ndig_d = '0;
            rptr_d = wptr_q;
            we0    = 1'b1;
            wk0    = TK_CLR;
            wptr_d = wnext;
        end else if (is_digit) begin
            if (nxt[W+3:W] == 4'b0000) begin
                acc_d = nxt[W-1:0];
                if (ndig_q != '1)
                    ndig_d = ndig_q + W'(1);
            end else begin
                drop_d = 1'b1;
            end
        end else if (cmd_i == IC_CLBK) begin
            if (entry_active) begin
                acc_d  = acc_q / W'(10);
                ndig_d = ndig_q - W'(1);
            end else begin
                drop_d = 1'b1;
            end
        end else if (is_tok) begin
            // The pending number and the command token go in together or not at all.
            if (free_slots >= need) begin
                acc_d  = '0;
                ndig_d = '0;
                we0    = 1'b1;
                if (entry_active) begin
                    wk0    = TK_NUM;
                    wv0    = acc_q;
                    we1    = 1'b1;
                    wk1    = ck;
                    wv1    = cv;
                    wptr_d = wptr_q + (AW+1)'(2);
                end else begin
                    wk0    = ck;
                    wv0    = cv;
                    wptr_d = wnext;
                end
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            ndig_q <= '0;
            drop_q <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            ndig_q <= ndig_d;
            drop_q <= drop_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we0) begin
            kind_mem[wptr_q[AW-1:0]] <= wk0;
            val_mem[wptr_q[AW-1:0]]  <= wv0;
        end
        if (we1) begin
            kind_mem[wnext[AW-1:0]] <= wk1;
            val_mem[wnext[AW-1:0]]  <= wv1;
        end
    end

    logic unused_none;
    assign unused_none = (IC_NONE == '0);

endmodule

// File: tb/tb_input_tokenizer.sv
// Directed bench for input_tokenizer: hand-computed expectations checked
// with immediate assertions after each step.
module tb_input_tokenizer;

    localparam int W    = 16;
    localparam int IC_N = 5;

    localparam logic [IC_N-1:0] NONE = 5'd0;
    localparam logic [IC_N-1:0] NUM0 = 5'd1;
    localparam logic [IC_N-1:0] OPAD = 5'd11;
    localparam logic [IC_N-1:0] OPMU = 5'd13;
    localparam logic [IC_N-1:0] EXLP = 5'd18;
    localparam logic [IC_N-1:0] EXRP = 5'd19;
    localparam logic [IC_N-1:0] CTOK = 5'd20;
    localparam logic [IC_N-1:0] CLBK = 5'd21;
    localparam logic [IC_N-1:0] CLCL = 5'd22;

    localparam logic [2:0] K_NUM = 3'd0, K_OP = 3'd1, K_LPAR = 3'd2,
                           K_RPAR = 3'd3, K_OK = 3'd4, K_CLR = 3'd5;

    logic            clk, rst;
    logic [IC_N-1:0] cmd;
    logic            tokValid, tokReady;
    logic [2:0]      tokKind;
    logic [W-1:0]    tokValue, entryVal;
    logic            entryActive, drop;

    int nAsserts = 0;
    int nFail    = 0;

    input_tokenizer #(.W(W), .DEPTH(4), .IC_N(IC_N)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_i          (cmd),
        .tok_valid_o    (tokValid),
        .tok_ready_i    (tokReady),
        .tok_kind_o     (tokKind),
        .tok_value_o    (tokValue),
        .entry_val_o    (entryVal),
        .entry_active_o (entryActive),
        .drop_o         (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock with the given command and ready; returns 1 time unit past the edge.
    task automatic applyStimulus(input logic [IC_N-1:0] c, input logic r);
        cmd      = c;
        tokReady = r;
        @(posedge clk);
        #1;
        cmd      = NONE;
        tokReady = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        assert (got === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic [2:0] k, input logic [W-1:0] v);
        checkOutput({tag, "_valid"}, {31'd0, tokValid}, 32'd1);
        checkOutput({tag, "_kind"}, {29'd0, tokKind}, {29'd0, k});
        checkOutput({tag, "_value"}, {16'd0, tokValue}, {16'd0, v});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, tokValid}, 32'd0);
        checkOutput({tag, "_kind"}, {29'd0, tokKind}, 32'd0);
        checkOutput({tag, "_value"}, {16'd0, tokValue}, 32'd0);
        checkOutput({tag, "_entry"}, {16'd0, entryVal}, 32'd0);
        checkOutput({tag, "_active"}, {31'd0, entryActive}, 32'd0);
        checkOutput({tag, "_drop"}, {31'd0, drop}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        cmd      = NONE;
        tokReady = 1'b0;
        #12;
        checkResetOutputs("reset");
        rst = 1'b0;

        // Build 123, then OPAD emits NUM then OP on consecutive pops.
        applyStimulus(NUM0 + 5'd1, 1'b1);
        checkOutput("d1_entry", {16'd0, entryVal}, 32'd1);
        checkOutput("d1_active", {31'd0, entryActive}, 32'd1);
        applyStimulus(NUM0 + 5'd2, 1'b1);
        checkOutput("d12_entry", {16'd0, entryVal}, 32'd12);
        applyStimulus(NUM0 + 5'd3, 1'b1);
        checkOutput("d123_entry", {16'd0, entryVal}, 32'd123);
        applyStimulus(OPAD, 1'b1);
        checkHead("opad_num", K_NUM, 16'd123);
        checkOutput("opad_active", {31'd0, entryActive}, 32'd0);
        checkOutput("opad_entry", {16'd0, entryVal}, 32'd0);
        applyStimulus(NONE, 1'b1);
        checkHead("opad_op", K_OP, 16'd0);
        applyStimulus(NONE, 1'b1);
        checkOutput("opad_empty", {31'd0, tokValid}, 32'd0);

        // Saturation boundary, overflow drop, and backspace down to nothing.
        applyStimulus(NUM0 + 5'd6, 1'b0);
        applyStimulus(NUM0 + 5'd5, 1'b0);
        applyStimulus(NUM0 + 5'd5, 1'b0);
        applyStimulus(NUM0 + 5'd3, 1'b0);
        applyStimulus(NUM0 + 5'd5, 1'b0);
        checkOutput("max_entry", {16'd0, entryVal}, 32'd65535);
        checkOutput("max_nodrop", {31'd0, drop}, 32'd0);
        applyStimulus(NUM0, 1'b0);
        checkOutput("ovf_drop", {31'd0, drop}, 32'd1);
        checkOutput("ovf_entry", {16'd0, entryVal}, 32'd65535);
        applyStimulus(NONE, 1'b0);
        checkOutput("ovf_drop_once", {31'd0, drop}, 32'd0);
        applyStimulus(CLBK, 1'b0);
        checkOutput("bk1_entry", {16'd0, entryVal}, 32'd6553);
        applyStimulus(CLBK, 1'b0);
        checkOutput("bk2_entry", {16'd0, entryVal}, 32'd655);
        applyStimulus(CLBK, 1'b0);
        applyStimulus(CLBK, 1'b0);
        checkOutput("bk4_entry", {16'd0, entryVal}, 32'd6);
        checkOutput("bk4_active", {31'd0, entryActive}, 32'd1);
        applyStimulus(CLBK, 1'b0);
        checkOutput("bk5_entry", {16'd0, entryVal}, 32'd0);
        checkOutput("bk5_active", {31'd0, entryActive}, 32'd0);
        checkOutput("bk5_nodrop", {31'd0, drop}, 32'd0);
        applyStimulus(CLBK, 1'b0);
        checkOutput("bk6_drop", {31'd0, drop}, 32'd1);

        // Backpressure: 3 tokens queued, a 2-slot push with 1 free is dropped whole.
        applyStimulus(EXLP, 1'b0);
        applyStimulus(NUM0 + 5'd7, 1'b0);
        applyStimulus(CTOK, 1'b0);
        checkHead("bp_head", K_LPAR, 16'd0);
        applyStimulus(NUM0 + 5'd4, 1'b0);
        applyStimulus(OPMU, 1'b0);
        checkOutput("bp_drop", {31'd0, drop}, 32'd1);
        checkOutput("bp_entry", {16'd0, entryVal}, 32'd4);
        checkOutput("bp_active", {31'd0, entryActive}, 32'd1);
        applyStimulus(NONE, 1'b1);
        checkHead("bp_pop1", K_NUM, 16'd7);
        applyStimulus(OPMU, 1'b0);
        checkOutput("bp_accept_nodrop", {31'd0, drop}, 32'd0);
        checkOutput("bp_accept_entry", {16'd0, entryVal}, 32'd0);
        checkHead("bp_h_num7", K_NUM, 16'd7);
        applyStimulus(NONE, 1'b1);
        checkHead("bp_h_ok", K_OK, 16'd0);
        applyStimulus(NONE, 1'b1);
        checkHead("bp_h_num4", K_NUM, 16'd4);
        applyStimulus(NONE, 1'b1);
        checkHead("bp_h_op2", K_OP, 16'd2);

        // Fill to full, then push and pop in the same cycle.
        applyStimulus(EXRP, 1'b0);
        applyStimulus(EXRP, 1'b0);
        applyStimulus(EXRP, 1'b0);
        applyStimulus(CTOK, 1'b1);
        checkOutput("full_pp_nodrop", {31'd0, drop}, 32'd0);
        checkHead("full_pp_head", K_RPAR, 16'd0);
        applyStimulus(CTOK, 1'b0);
        checkOutput("full_drop", {31'd0, drop}, 32'd1);

        // Clear with 3 queued and a concurrent pop leaves only CLR.
        applyStimulus(NONE, 1'b1);
        applyStimulus(NUM0 + 5'd9, 1'b0);
        checkOutput("pre_clr_entry", {16'd0, entryVal}, 32'd9);
        applyStimulus(CLCL, 1'b1);
        checkHead("clr_head", K_CLR, 16'd0);
        checkOutput("clr_entry", {16'd0, entryVal}, 32'd0);
        checkOutput("clr_active", {31'd0, entryActive}, 32'd0);
        checkOutput("clr_nodrop", {31'd0, drop}, 32'd0);
        applyStimulus(NONE, 1'b1);
        checkOutput("clr_count1", {31'd0, tokValid}, 32'd0);

        // Asynchronous reset mid-entry.
        applyStimulus(EXLP, 1'b0);
        applyStimulus(EXRP, 1'b0);
        applyStimulus(NUM0 + 5'd4, 1'b0);
        applyStimulus(NUM0 + 5'd2, 1'b0);
        checkOutput("pre_rst_entry", {16'd0, entryVal}, 32'd42);
        checkHead("pre_rst_head", K_LPAR, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(NUM0 + 5'd5, 1'b0);
        checkOutput("post_rst_entry", {16'd0, entryVal}, 32'd5);
        checkOutput("post_rst_valid", {31'd0, tokValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
